regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the CPU STORE stage.
//  - Two registered read ports (A/B) and one write port serve the pipeline.
//  - A separate handshaked bus port (cs_/as_/we_/rdy_) with programmable wait states serves debug/DMA access.
//  - Sits between the decode/writeback stages and the system bus.

---
 rtl/regfile_mp.sv | 176 +++++++++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port register file for the CPU STORE stage.
//
// Two registered pipeline read ports (A/B) and one pipeline write port, plus a
// handshaked bus port (cs_/as_/we_/rdy_) with WAIT_CYC programmable wait
// states for debug/DMA access. Entries at index >= DEPTH do not exist: writes
// to them are dropped and reads from them return 0.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   -> read ports A/B forward w_data when a pipeline write hits the
//                address they are reading in the same cycle.
//   undefined -> read ports return the pre-write contents in that cycle.
//
// Ports:
//   clk, reset_          clock (posedge) / asynchronous active-low reset
//   ra_addr -> ra_data   read port A, 1-cycle latency
//   rb_addr -> rb_data   read port B, 1-cycle latency
//   w_en_, w_addr,       pipeline write port, w_en_ active-low
//   w_data
//   cs_, as_, we_,       bus request: chip select, address strobe (both
//   addr, d_in           active-low), we_ 0=write/1=read, address, write data
//   d_out, rdy_          bus read data (held until next bus read completes),
//                        ready (active-low, one-cycle pulse)
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              w_en_,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              cs_,
  input  logic              as_,
  input  logic              we_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              rdy_
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_END} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_C  = 4'(WAIT_CYC);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] ra_data_q, ra_data_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              rdy_q, rdy_d;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              lat_rd_q, lat_rd_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              pipe_wr;
  logic              bus_wr;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic [DATA_W-1:0] rd_mem(input logic [ADDR_W-1:0] a);
    return in_range(a) ? mem_q[a] : '0;
  endfunction

  // Storage and pipeline read ports.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pipe_wr = !w_en_ && in_range(w_addr);
    // The bus write commits at the ACK edge; a pipeline write to the same
    // entry in that cycle wins and the bus data is discarded.
    bus_wr  = (state_q == ST_ACK) && !lat_rd_q && in_range(lat_addr_q) &&
              !(pipe_wr && (w_addr == lat_addr_q));

    mem_d = mem_q;
    if (pipe_wr) mem_d[w_addr]    = w_data;
    if (bus_wr)  mem_d[lat_addr_q] = lat_data_q;

`ifdef REGFILE_BYPASS_EN
    ra_data_d = (pipe_wr && (w_addr == ra_addr)) ? w_data : rd_mem(ra_addr);
    rb_data_d = (pipe_wr && (w_addr == rb_addr)) ? w_data : rd_mem(rb_addr);
`else
    ra_data_d = rd_mem(ra_addr);
    rb_data_d = rd_mem(rb_addr);
`endif
  end

  // Bus handshake FSM: IDLE -> [WAIT] -> ACK -> END -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_rd_d   = lat_rd_q;
    lat_data_d = lat_data_q;
    d_out_d    = d_out_q;
    rdy_d      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!cs_ && !as_) begin
          lat_addr_d = addr;
          lat_rd_d   = we_;
          lat_data_d = d_in;
          cnt_d      = WAIT_C;
          state_d    = (WAIT_C == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Request pins are ignored here; the latched request completes.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // rdy_ and the read data land on the same edge; the read sees the
        // pre-edge contents (no forwarding on the bus port).
        rdy_d   = 1'b0;
        if (lat_rd_q) d_out_d = rd_mem(lat_addr_q);
        state_d = ST_END;
      end
      ST_END: begin
        // A new access needs as_ released first.
        if (as_) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      // NOTE: the entries are architecturally cleared by reset, so the array
      // is reset here along with the control flops.
      mem_q      <= '{default: '0};
      ra_data_q  <= '0;
      rb_data_q  <= '0;
      d_out_q    <= '0;
      rdy_q      <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_rd_q   <= 1'b1;
      lat_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q      <= mem_d;
      ra_data_q  <= ra_data_d;
      rb_data_q  <= rb_data_d;
      d_out_q    <= d_out_d;
      rdy_q      <= rdy_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_rd_q   <= lat_rd_d;
      lat_data_q <= lat_data_d;
    end
  end

  assign ra_data = ra_data_q;
  assign rb_data = rb_data_q;
  assign d_out   = d_out_q;
  assign rdy_    = rdy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (DEPTH=24, WAIT_CYC=3).
// A behavioural model of the entries supplies expected values; expected read
// data is queued when a read is issued and compared when the DUT returns it.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 24;
  localparam int ADDR_W   = 5;
  localparam int WAIT_CYC = 3;
  localparam int LAT      = WAIT_CYC + 2;  // request edge to rdy_ edge

  logic              clk;
  logic              reset_;
  logic [ADDR_W-1:0] ra_addr, rb_addr, w_addr, addr;
  logic [DATA_W-1:0] ra_data, rb_data, w_data, d_in, d_out;
  logic              w_en_, cs_, as_, we_, rdy_;

  regfile_mp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk(clk), .reset_(reset_),
    .ra_addr(ra_addr), .ra_data(ra_data),
    .rb_addr(rb_addr), .rb_data(rb_data),
    .w_en_(w_en_), .w_addr(w_addr), .w_data(w_data),
    .cs_(cs_), .as_(as_), .we_(we_), .addr(addr), .d_in(d_in),
    .d_out(d_out), .rdy_(rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  logic [31:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) ? model[a] : 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_dout = 32'h0;
  endtask

  task automatic pipe_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    w_en_ = 1'b0; w_addr = a; w_data = d;
    @(posedge clk); #1;
    w_en_ = 1'b1;
    if (int'(a) < DEPTH) model[a] = d;
  endtask

  task automatic pipe_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                           input string tag);
    @(negedge clk);
    ra_addr = a; rb_addr = b;
    exp_q.push_back(model_rd(a));
    exp_q.push_back(model_rd(b));
    @(posedge clk); #1;
    check({tag, " ra"}, ra_data, exp_q.pop_front());
    check({tag, " rb"}, rb_data, exp_q.pop_front());
  endtask

  // One bus access with as_ held low after rdy_. Optionally a pipeline write
  // (ca/cd) is aimed at the ACK edge to exercise collisions.
  task automatic bus_access(input logic rd, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic coll,
                            input logic [ADDR_W-1:0] ca, input logic [31:0] cd,
                            input string tag);
    int n;
    int extra;
    logic done;
    logic [31:0] e;
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; we_ = rd; addr = a; d_in = d;
    if (rd) exp_q.push_back(model_rd(a));
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      w_en_ = 1'b1;
      if (rdy_ == 1'b0) done = 1'b1;
      else if (coll && n == LAT - 1) begin
        w_en_ = 1'b0; w_addr = ca; w_data = cd;
      end
    end
    check({tag, " latency"}, n, LAT);
    if (coll && int'(ca) < DEPTH) model[ca] = cd;
    if (!rd && int'(a) < DEPTH && !(coll && ca == a)) model[a] = d;
    if (rd) begin
      e = exp_q.pop_front();
      check({tag, " d_out"}, d_out, e);
      exp_dout = e;
    end else begin
      check({tag, " d_out held"}, d_out, exp_dout);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rdy_ == 1'b0) extra++;
    end
    check({tag, " single rdy"}, extra, 0);
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_ = 1'b0;
    cs_ = 1'b1; as_ = 1'b1; we_ = 1'b1; addr = '0; d_in = '0;
    w_en_ = 1'b1; w_addr = '0; w_data = '0; ra_addr = '0; rb_addr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset ra_data", ra_data, 32'h0);
    check("reset rb_data", rb_data, 32'h0);
    check("reset d_out", d_out, 32'h0);
    check("reset rdy_", rdy_, 1'b1);
    @(negedge clk);
    reset_ = 1'b1;

    // Pipeline write then read back on both ports.
    pipe_write(5'd5, 32'hDEADBEEF);
    pipe_read(5'd5, 5'd5, "pipe rd5");
    pipe_read(5'd0, 5'd5, "pipe rd0/5");

    // Bus read of entry 5 with wait states.
    bus_access(1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0, "bus rd5");

    // Same-address collision: pipeline wins, rdy_ still pulses.
    bus_access(1'b0, 5'd7, 32'h2, 1'b1, 5'd7, 32'h1, "coll same");
    pipe_read(5'd7, 5'd7, "after coll7");

    // Different-address collision: both land.
    bus_access(1'b0, 5'd10, 32'h22, 1'b1, 5'd11, 32'h33, "coll diff");
    pipe_read(5'd10, 5'd11, "after coll10/11");

    // Bus read of an entry written by the pipeline at the ACK edge: old data.
    bus_access(1'b1, 5'd5, 32'h0, 1'b1, 5'd5, 32'hCAFE0001, "rd coll");
    pipe_read(5'd5, 5'd7, "after rdcoll");

    // Read/write collision on port B.
    @(negedge clk);
    rb_addr = 5'd9; w_en_ = 1'b0; w_addr = 5'd9; w_data = 32'h55;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h55);
`else
    exp_q.push_back(model_rd(5'd9));
`endif
    @(posedge clk); #1;
    w_en_ = 1'b1;
    model[9] = 32'h55;
    check("bypass rb", rb_data, exp_q.pop_front());
    pipe_read(5'd9, 5'd9, "after bypass");

    // Unmapped address 30 via both ports.
    pipe_write(5'd30, 32'h1234);
    bus_access(1'b0, 5'd30, 32'h5678, 1'b0, 5'd0, 32'h0, "bus wr30");
    bus_access(1'b1, 5'd30, 32'h0, 1'b0, 5'd0, 32'h0, "bus rd30");
    pipe_read(5'd30, 5'd31, "unmapped");

    // Full sweep against the model.
    for (int i = 0; i < 32; i += 2) pipe_read(5'(i), 5'(i + 1), "sweep");

    // Reset in the middle of a bus write.
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; we_ = 1'b0; addr = 5'd3; d_in = 32'hAA;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    check("midrst rdy_", rdy_, 1'b1);
    check("midrst d_out", d_out, 32'h0);
    check("midrst ra", ra_data, 32'h0);
    cs_ = 1'b1; as_ = 1'b1;
    model_clear();
    @(negedge clk);
    reset_ = 1'b1;
    pipe_read(5'd3, 5'd5, "post rst");
    bus_access(1'b0, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, "post rst wr");
    bus_access(1'b1, 5'd3, 32'h0, 1'b0, 5'd0, 32'h0, "post rst rd");
    pipe_read(5'd3, 5'd11, "post rst pipe");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
